// File: rtl/framing_pkg.sv
// Shared definitions for the header-framed packed-pixel protocol.
// Framer and deframer both import this so header values, state encoding
// and counter widths cannot drift apart.
package framing_pkg;

  localparam logic [7:0] HEADER_BYTE0 = 8'hA5;
  localparam logic [7:0] HEADER_BYTE1 = 8'h5A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR0    = 2'd1,
    HDR1    = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  // Width of a counter over n positions (0..n-1); never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/header_packer_elem_packer.sv
// Lane counter plus pack register: gathers PackedNum elements LSB-first
// and presents the completed byte combinationally with the last element.
//
// Handshakes: an element moves when valid_i & ready_o; a byte moves when
// byte_valid_o & byte_ready_i. The byte handshake and the last-lane
// element handshake are the same event, so ready_o drops only on the
// last lane while the byte sink is full.
module elem_packer
  import framing_pkg::*;
#(
  parameter int unsigned UnpackedWidth = 1,
  parameter int unsigned BusWidth      = 8,
  parameter int unsigned PackedNum     = BusWidth / UnpackedWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [UnpackedWidth-1:0] unpacked_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [BusWidth-1:0]      byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i
);

  localparam int unsigned      LaneW    = cnt_width(PackedNum);
  localparam logic [LaneW-1:0] LastLane = LaneW'(PackedNum - 1);

  logic [LaneW-1:0]    r_lane;
  logic [BusWidth-1:0] r_pack;
  logic                w_last;
  logic                w_accept;

  assign w_last       = (r_lane == LastLane);
  assign ready_o      = ~w_last | byte_ready_i;
  assign w_accept     = valid_i & ready_o;
  assign byte_valid_o = valid_i & w_last;

  // Completed byte: lower lanes from the pack register, top lane straight from the input.
  always_comb begin
    byte_o = r_pack;
    byte_o[(PackedNum-1)*UnpackedWidth +: UnpackedWidth] = unpacked_i;
  end

  // Store each accepted element in its lane and advance the lane counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (w_accept) begin
      r_pack[int'(r_lane)*UnpackedWidth +: UnpackedWidth] <= unpacked_i;
      r_lane <= w_last ? '0 : r_lane + 1'b1;
    end
  end

endmodule

// File: rtl/header_packer.sv
// Transmit-side framer: emits HeaderByte0, HeaderByte1, then PacketLenBytes
// bytes each packing PackedNum elements LSB-first. One output register
// drives data_o/valid_o; it holds while valid_o & ~ready_i.
//
// Handshakes: an element moves when valid_i & ready_o; a byte moves when
// valid_o & ready_i. valid_o never drops without a transfer.
module header_packer
  import framing_pkg::*;
#(
  parameter int unsigned         UnpackedWidth  = 1,
  parameter int unsigned         BusWidth       = 8,
  parameter int unsigned         PackedNum      = BusWidth / UnpackedWidth,
  parameter int unsigned         PacketLenBytes = 9600,
  parameter logic [BusWidth-1:0] HeaderByte0    = HEADER_BYTE0,
  parameter logic [BusWidth-1:0] HeaderByte1    = HEADER_BYTE1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [UnpackedWidth-1:0] unpacked_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [BusWidth-1:0]      data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     packet_done_o,
  output state_e                   state_o
);

  if (BusWidth != UnpackedWidth * PackedNum) begin : g_bad_width
    $error("header_packer: BusWidth must equal UnpackedWidth*PackedNum");
  end
  if (PacketLenBytes < 1) begin : g_bad_len
    $error("header_packer: PacketLenBytes must be at least 1");
  end

  localparam int unsigned      ByteW = $clog2(PacketLenBytes + 1);
  localparam logic [ByteW-1:0] LenC  = ByteW'(PacketLenBytes);

  state_e              r_state;
  state_e              w_next;
  logic [BusWidth-1:0] r_out;
  logic                r_out_valid;
  logic [ByteW-1:0]    r_byte_cnt;

  logic                w_xfer;
  logic                w_open;
  logic                w_last_xfer;
  logic                w_pk_valid;
  logic                w_pk_ready;
  logic [BusWidth-1:0] w_pk_byte;
  logic                w_pk_byte_valid;
  logic                w_room;
  logic                w_byte_load;
  logic                w_load;
  logic [BusWidth-1:0] w_load_data;

  assign w_xfer      = r_out_valid & ready_i;
  // Payload accepts elements only until the packet's last byte is loaded.
  assign w_open      = (r_state == PAYLOAD) & (r_byte_cnt != LenC);
  assign w_last_xfer = (r_state == PAYLOAD) & (r_byte_cnt == LenC) & w_xfer;
  assign w_pk_valid  = valid_i & w_open;
  assign w_room      = ~r_out_valid | ready_i;
  assign w_byte_load = w_pk_byte_valid & w_room;

  elem_packer #(
    .UnpackedWidth(UnpackedWidth),
    .BusWidth     (BusWidth),
    .PackedNum    (PackedNum)
  ) u_elem_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .unpacked_i  (unpacked_i),
    .valid_i     (w_pk_valid),
    .ready_o     (w_pk_ready),
    .byte_o      (w_pk_byte),
    .byte_valid_o(w_pk_byte_valid),
    .byte_ready_i(w_room)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: header bytes advance on transfer, payload ends on last byte transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_next = HDR0;
      HDR0:    if (w_xfer)  w_next = HDR1;
      HDR1:    if (w_xfer)  w_next = PAYLOAD;
      PAYLOAD: if (w_last_xfer) w_next = valid_i ? HDR0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode: element ready, done pulse and what (if anything) loads the output register.
  always_comb begin
    w_load        = 1'b0;
    w_load_data   = '0;
    ready_o       = 1'b0;
    packet_done_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_load      = 1'b1;
          w_load_data = HeaderByte0;
        end
      end
      HDR0: begin
        if (w_xfer) begin
          w_load      = 1'b1;
          w_load_data = HeaderByte1;
        end
      end
      PAYLOAD: begin
        ready_o = w_open & w_pk_ready;
        if (w_byte_load) begin
          w_load      = 1'b1;
          w_load_data = w_pk_byte;
        end
        if (w_last_xfer) begin
          packet_done_o = 1'b1;
          if (valid_i) begin
            w_load      = 1'b1;
            w_load_data = HeaderByte0;
          end
        end
      end
      default: ;
    endcase
  end

  // Output register and payload byte counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_byte_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_out       <= w_load_data;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_last_xfer)      r_byte_cnt <= '0;
      else if (w_byte_load) r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign data_o  = r_out;
  assign valid_o = r_out_valid;
  assign state_o = r_state;

endmodule

// File: tb/tb_header_packer.sv
// Directed bench for header_packer with 1-bit elements, 8 per byte and
// 2-byte packets. Expected bytes ({done, byte}) are queued by the driver
// and popped by a monitor on every output transfer.
module tb_header_packer;
  import framing_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:0] unpacked_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       packet_done_o;
  state_e     state_o;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit chk_gap = 0;

  logic [8:0] exp_q[$];

  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_gap_chk;

  header_packer #(
    .UnpackedWidth (1),
    .BusWidth      (8),
    .PackedNum     (8),
    .PacketLenBytes(2),
    .HeaderByte0   (8'hA5),
    .HeaderByte1   (8'h5A)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .unpacked_i   (unpacked_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .packet_done_o(packet_done_o),
    .state_o      (state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ~ready_i;
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard / monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check_val("hold_valid", 32'(valid_o), 32'd1);
        check_val("hold_data", 32'(data_o), 32'(prev_data));
      end
      if (prev_gap_chk)
        check_val("b2b_no_gap", {23'd0, valid_o, data_o}, {23'd0, 1'b1, 8'hA5});
      if (ready_o && state_o != PAYLOAD)
        check_val("ready_outside_payload", 32'(ready_o), 32'd0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check_val("unexpected_byte", 32'(exp_q.size()), 32'd1);
        else check_val("byte", {23'd0, packet_done_o, data_o}, {23'd0, exp_q.pop_front()});
      end else if (packet_done_o) begin
        check_val("spurious_done", 32'(packet_done_o), 32'd0);
      end
    end
    prev_stall   <= rst_n & valid_o & ~ready_i;
    prev_data    <= data_o;
    prev_gap_chk <= rst_n & chk_gap & valid_o & ready_i & packet_done_o & valid_i;
  end

  // driver tasks
  task automatic send_elem(input logic b);
    bit done = 0;
    valid_i    = 1'b1;
    unpacked_i = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ready_o) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check_val("elem_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_elem(b[i]);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input bit hold);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b1, b1});
    send_byte(b0);
    send_byte(b1);
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    unpacked_i = 1'b0;
    ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid_o", 32'(valid_o), 32'd0);
    check_val("rst_data_o", 32'(data_o), 32'd0);
    check_val("rst_ready_o", 32'(ready_o), 32'd0);
    check_val("rst_done", 32'(packet_done_o), 32'd0);
    check_val("rst_state", 32'(state_o), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // idle: no header without valid_i
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o || ready_o) check_val("idle_quiet", {30'd0, valid_o, ready_o}, 32'd0);
    end
    check_val("idle_valid_o", 32'(valid_o), 32'd0);
    check_val("idle_state", 32'(state_o), 32'(IDLE));
    @(posedge clk); #1;

    // basic packet: A5 5A 0D FF, back to IDLE
    send_packet(8'h0D, 8'hFF, 0);
    wait_drain();
    repeat (2) @(negedge clk);
    check_val("pkt_state_idle", 32'(state_o), 32'(IDLE));
    check_val("pkt_valid_low", 32'(valid_o), 32'd0);

    // same packet with ready toggling
    @(posedge clk); #1;
    ready_mode = 1;
    send_packet(8'h0D, 8'hFF, 0);
    wait_drain();
    repeat (2) @(negedge clk);
    check_val("toggle_state_idle", 32'(state_o), 32'(IDLE));

    // back-to-back packets with valid held high
    @(posedge clk); #1;
    ready_mode = 0;
    chk_gap    = 1;
    send_packet(8'h96, 8'h3C, 1);
    send_packet(8'h01, 8'h80, 0);
    wait_drain();
    chk_gap = 0;

    // reset mid-payload after 5 elements
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    for (int i = 0; i < 5; i++) send_elem(1'b1);
    check_val("pre_rst_q_empty", 32'(exp_q.size()), 32'd0);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_valid_o", 32'(valid_o), 32'd0);
    check_val("midrst_data_o", 32'(data_o), 32'd0);
    check_val("midrst_state", 32'(state_o), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_packet(8'h00, 8'h81, 0);
    wait_drain();

    // random downstream ready with random payload bytes
    @(posedge clk); #1;
    ready_mode = 2;
    for (int p = 0; p < 3; p++)
      send_packet(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), p != 2);
    wait_drain();
    repeat (3) @(negedge clk);
    check_val("final_state_idle", 32'(state_o), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
